// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for a shared W-bit datapath port.
// Holds the grant while the owner requests, with optional forced release.
module rr_mux_arbiter #(
  parameter int N       = 4,
  parameter int SW      = 2,
  parameter int W       = 32,
  parameter int MAXHOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] d_in,
  output logic [N-1:0]   grant,
  output logic [SW-1:0]  sel,
  output logic           busy,
  output logic           timeout,
  output logic [W-1:0]   d_out
);

  localparam int CW = (MAXHOLD > 0) ?
    $clog2(MAXHOLD + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAXHOLD);
  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam bit TO_EN = (MAXHOLD != 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [SW-1:0]   ptr_q;
  logic [SW-1:0]   ptr_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [N-1:0]    grant_d;
  logic [SW-1:0]   sel_d;
  logic            busy_d;
  logic            timeout_d;
  logic            pick_vld;
  logic [SW-1:0]   pick_idx;
  logic            own_req;
  logic            hold_hit;
  logic            cnt_sat;
  logic [W-1:0]    slice [N];

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign slice[g] = d_in[g*W +: W];
  end

  // first set request scanning upward from ptr, wrapping at N
  always_comb begin
    int            j;
    logic [SW-1:0] jj;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    jj       = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      jj = SW'(j);
      if (!pick_vld && req[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

  assign own_req  = req[sel];
  assign hold_hit = TO_EN && (cnt_q == CMAX);
  assign cnt_sat  = &cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
      sel     <= sel_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) state_d = GRANT;
      end
      GRANT: begin
        if (!own_req || hold_hit)
          state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_d   = grant;
    sel_d     = sel;
    busy_d    = busy;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (pick_vld) begin
          grant_d[pick_idx] = 1'b1;
          sel_d  = pick_idx;
          busy_d = 1'b1;
          cnt_d  = CW'(1);
        end
      end
      GRANT: begin
        unique case (1'b1)
          (!own_req),
          (own_req && hold_hit): begin
            grant_d   = '0;
            sel_d     = '0;
            busy_d    = 1'b0;
            cnt_d     = '0;
            timeout_d = own_req;
            // released owner drops to lowest priority
            ptr_d = (sel == LAST) ? '0 :
                    sel + SW'(1);
          end
          (own_req && !hold_hit): begin
            if (!cnt_sat)
              cnt_d = cnt_q + CW'(1);
          end
        endcase
      end
    endcase
  end

  always_comb begin
    d_out = '0;
    if (busy) d_out = slice[sel];
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(grant));

  a_busy: assert property (
    @(posedge clk) disable iff (reset)
    busy == (|grant));

  a_pulse: assert property (
    @(posedge clk) disable iff (reset)
    timeout |=> !timeout);

  a_sel: assert property (
    @(posedge clk) disable iff (reset)
    sel <= LAST);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Vector-table bench for rr_mux_arbiter with a queue scoreboard
// and a hand-driven async reset sequence.
module tb_rr_mux_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] d_in;
  logic [3:0]   grant;
  logic [1:0]   sel;
  logic         busy;
  logic         timeout;
  logic [31:0]  d_out;

  logic [31:0]  dat [4];

  int n_chk;
  int n_pass;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       t;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  rr_mux_arbiter #(
    .N(4), .SW(2), .W(32), .MAXHOLD(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .d_in(d_in),
    .grant(grant),
    .sel(sel),
    .busy(busy),
    .timeout(timeout),
    .d_out(d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h",
                  nm, act, exp);
  endtask

  function automatic void add(input logic r,
                              input logic [3:0] q,
                              input logic [3:0] g,
                              input logic [1:0] s,
                              input logic b,
                              input logic t);
    vec_t v;
    v.rst = r; v.req = q; v.g = g;
    v.s = s; v.b = b; v.t = t;
    vecs.push_back(v);
  endfunction

  function automatic logic [3:0] oh(input int k);
    logic [3:0] m;
    m = 4'b0001;
    return m << k;
  endfunction

  initial begin
    vec_t e;
    vec_t v;
    logic [31:0] exp_d;
    n_chk  = 0;
    n_pass = 0;
    dat[0] = 32'h1111_0000;
    dat[1] = 32'h2222_0001;
    dat[2] = 32'hDEAD_BEEF;
    dat[3] = 32'h4444_0003;
    for (int k = 0; k < 4; k++)
      d_in[k*32 +: 32] = dat[k];
    reset = 1'b1;
    req   = 4'b0000;

    // reset with no requests, then idle
    add(1, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
    // single requester 2
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    // rotation, each owner drops after 3 cycles
    add(1, 4'b0000, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++)
        add(0, 4'b1111, oh(k), 2'(k), 1, 0);
      add(0, 4'b1111 & ~oh(k), 4'b0000, 0, 0, 0);
    end
    add(0, 4'b1111, 4'b0001, 0, 1, 0);
    add(0, 4'b1110, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    // timeout with req 0011 held
    add(1, 4'b0000, 4'b0000, 0, 0, 0);
    for (int c = 0; c < 8; c++)
      add(0, 4'b0011, 4'b0001, 0, 1, 0);
    add(0, 4'b0011, 4'b0000, 0, 0, 1);
    for (int c = 0; c < 8; c++)
      add(0, 4'b0011, 4'b0010, 1, 1, 0);
    add(0, 4'b0011, 4'b0000, 0, 0, 1);
    add(0, 4'b0011, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    // late request rising as owner 1 releases
    add(0, 4'b0010, 4'b0010, 1, 1, 0);
    add(0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    // sole requester times out and is regranted
    for (int c = 0; c < 8; c++)
      add(0, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 4'b0000, 0, 0, 1);
    add(0, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      reset = v.rst;
      req   = v.req;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      exp_d = e.b ? dat[e.s] : 32'h0;
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(e.g));
      chk($sformatf("v%0d sel", i), 32'(sel), 32'(e.s));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(e.b));
      chk($sformatf("v%0d timeout", i),
          32'(timeout), 32'(e.t));
      chk($sformatf("v%0d d_out", i), d_out, exp_d);
    end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    // async reset in the middle of a grant
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b1000;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) @(posedge clk);
    #1;
    chk("mid grant owner", 32'(grant), 32'h8);
    chk("mid grant sel", 32'(sel), 32'd3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async grant", 32'(grant), 32'h0);
    chk("async busy", 32'(busy), 32'h0);
    chk("async sel", 32'(sel), 32'h0);
    chk("async d_out", d_out, 32'h0);
    reset = 1'b0;
    req   = 4'b1001;
    @(posedge clk);
    #1;
    chk("post reset grant", 32'(grant), 32'h1);
    chk("post reset sel", 32'(sel), 32'h0);
    chk("post reset d_out", d_out, dat[0]);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("post reset release", 32'(grant), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
